// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and level interrupt
module uart_tx #(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] DIVISOR_RESET = 16'h000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_write,
    input  logic [15:0] divisor_in,
    input  logic [1:0]  divisor_write,
    input  logic [7:0]  config_in,
    input  logic        config_write,
    output logic [15:0] divisor_out,
    output logic [7:0]  config_out,
    output logic [7:0]  status_out,
    output logic        tx,
    output logic        tx_int
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   divisor;
    logic          en;
    logic          ie;
    logic          ovf;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   bit_cnt;
    logic          tx_q;

    logic          empty;
    logic          full;
    logic          busy;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic [31:0]   count_ext;
    logic [3:0]    count_sat;
    logic          unused_cfg;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign busy      = (state != IDLE);
    assign pop       = (state == IDLE) && en && !empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign push      = data_write && (!full || pop);
    assign ovf_set   = data_write && full && !pop;
    assign count_ext = 32'(count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    assign unused_cfg = ^config_in[6:2];

    assign divisor_out = divisor;
    assign config_out  = {6'b0, ie, en};
    assign status_out  = {count_sat, ovf, empty, full, busy};
    assign tx          = tx_q;
    assign tx_int      = ie & empty & ~busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor <= DIVISOR_RESET;
            en      <= 1'b0;
            ie      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (divisor_write[0]) divisor[7:0]  <= divisor_in[7:0];
            if (divisor_write[1]) divisor[15:8] <= divisor_in[15:8];
            if (config_write) begin
                en <= config_in[0];
                ie <= config_in[1];
            end
            if (ovf_set)
                ovf <= 1'b1;
            else if (config_write && config_in[7])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Each bit reloads bit_cnt from the live divisor, so divisor writes apply from the next bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= 8'h00;
            bit_idx <= 3'd0;
            bit_cnt <= 16'd0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= divisor;
                        state   <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= divisor;
                        bit_idx <= 3'd0;
                        tx_q    <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= divisor;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_q    <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt == 16'd0)
                        state <= IDLE;
                    else
                        bit_cnt <= bit_cnt - 16'd1;
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed scoreboard bench for uart_tx
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_write = 1'b0;
    logic [15:0] divisor_in = 16'h0000;
    logic [1:0]  divisor_write = 2'b00;
    logic [7:0]  config_in = 8'h00;
    logic        config_write = 1'b0;
    logic [15:0] divisor_out;
    logic [7:0]  config_out;
    logic [7:0]  status_out;
    logic        tx;
    logic        tx_int;

    int checks = 0;
    int failures = 0;
    int lens [10];
    logic [7:0] sb [$];

    uart_tx #(.FIFO_DEPTH(4), .DIVISOR_RESET(16'h000F)) dut (
        .clk(clk), .reset(reset),
        .data_in(data_in), .data_write(data_write),
        .divisor_in(divisor_in), .divisor_write(divisor_write),
        .config_in(config_in), .config_write(config_write),
        .divisor_out(divisor_out), .config_out(config_out), .status_out(status_out),
        .tx(tx), .tx_int(tx_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_in = b; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic write_cfg(input logic [7:0] v);
        config_in = v; config_write = 1'b1;
        @(negedge clk);
        config_write = 1'b0;
    endtask

    task automatic write_div(input logic [15:0] v, input logic [1:0] be);
        divisor_in = v; divisor_write = be;
        @(negedge clk);
        divisor_write = 2'b00;
    endtask

    task automatic set_lens(input int d);
        for (int i = 0; i < 10; i++) lens[i] = d + 1;
    endtask

    // inj_kind 1 writes the divisor, 2 writes config, during sample inj_idx of the frame
    task automatic run_frame(input int inj_idx, input int inj_kind, input logic [15:0] inj_val,
                             input bit chk_int, output int waited);
        logic [7:0] exp_byte;
        logic       exp_bit;
        int         idx;
        waited = 0;
        while (tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("frame_start", tx, 1'b0);
        check("sb_nonempty", sb.size() != 0, 1'b1);
        exp_byte = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        idx = 0;
        for (int b = 0; b < 10; b++) begin
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_byte[b-1];
            for (int s = 0; s < lens[b]; s++) begin
                check($sformatf("byte%02h_bit%0d_s%0d", exp_byte, b, s), tx, exp_bit);
                if (chk_int) check("int_low_in_frame", tx_int, 1'b0);
                if (idx == inj_idx && inj_kind == 1) begin
                    divisor_in = inj_val; divisor_write = 2'b11;
                end
                if (idx == inj_idx && inj_kind == 2) begin
                    config_in = inj_val[7:0]; config_write = 1'b1;
                end
                @(negedge clk);
                divisor_write = 2'b00;
                config_write = 1'b0;
                idx++;
            end
        end
    endtask

    initial begin
        int  w;
        bit  went_low;

        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_status", status_out, 8'h04);
        check("rst_int", tx_int, 1'b0);
        check("rst_div", divisor_out, 16'h000F);
        check("rst_cfg", config_out, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        // single byte, divisor 3
        write_div(16'h0003, 2'b11);
        write_cfg(8'h01);
        check("cfg_en", config_out, 8'h01);
        check("div3", divisor_out, 16'h0003);
        write_byte(8'hA5); sb.push_back(8'hA5);
        set_lens(3);
        run_frame(-1, 0, 16'h0, 1'b0, w);
        check("latency_a5", w, 1);
        check("idle_after_a5", status_out, 8'h04);

        // back-to-back, divisor 0
        write_cfg(8'h00);
        write_div(16'h0000, 2'b11);
        write_byte(8'h00); sb.push_back(8'h00);
        write_byte(8'hFF); sb.push_back(8'hFF);
        write_byte(8'h55); sb.push_back(8'h55);
        write_cfg(8'h01);
        set_lens(0);
        run_frame(-1, 0, 16'h0, 1'b0, w);
        check("b2b_first_wait", w, 1);
        run_frame(-1, 0, 16'h0, 1'b0, w);
        check("b2b_gap2", w, 1);
        run_frame(-1, 0, 16'h0, 1'b0, w);
        check("b2b_gap3", w, 1);
        check("b2b_done_status", status_out, 8'h04);

        // overflow, then full write with simultaneous pop
        write_cfg(8'h00);
        write_div(16'h0003, 2'b11);
        write_byte(8'h10); sb.push_back(8'h10);
        write_byte(8'h20); sb.push_back(8'h20);
        write_byte(8'h30); sb.push_back(8'h30);
        write_byte(8'h40); sb.push_back(8'h40);
        write_byte(8'hEE);
        check("ovf_status", status_out, 8'h4A);
        write_cfg(8'h81);
        check("ovf_cleared_status", status_out, 8'h42);
        check("ovf_cfg", config_out, 8'h01);
        write_byte(8'h5A); sb.push_back(8'h5A);
        check("full_push_pop_status", status_out, 8'h43);
        set_lens(3);
        run_frame(-1, 0, 16'h0, 1'b0, w);
        check("ovf_first_wait", w, 0);
        for (int i = 0; i < 4; i++) begin
            run_frame(-1, 0, 16'h0, 1'b0, w);
            check("ovf_gap", w, 1);
        end
        check("ovf_done_status", status_out, 8'h04);
        check("sb_drained", sb.size(), 0);
        went_low = 1'b0;
        repeat (30) begin
            if (tx !== 1'b1) went_low = 1'b1;
            @(negedge clk);
        end
        check("dropped_byte_not_sent", went_low, 1'b0);

        // interrupt and divisor change mid-DATA
        write_div(16'h0001, 2'b11);
        write_cfg(8'h03);
        check("int_idle_empty", tx_int, 1'b1);
        write_byte(8'h3C); sb.push_back(8'h3C);
        check("int_low_after_push", tx_int, 1'b0);
        lens[0] = 2; lens[1] = 2;
        for (int i = 2; i < 10; i++) lens[i] = 8;
        run_frame(2, 1, 16'h0007, 1'b1, w);
        check("div_change_wait", w, 1);
        check("int_after_stop", tx_int, 1'b1);
        check("div7", divisor_out, 16'h0007);
        write_div(16'hAB01, 2'b01);
        check("div_byte_enable", divisor_out, 16'h0001);

        // EN cleared mid-frame
        write_byte(8'h96); sb.push_back(8'h96);
        write_byte(8'h69); sb.push_back(8'h69);
        set_lens(1);
        run_frame(5, 2, 16'h0002, 1'b1, w);
        check("en_clear_wait", w, 0);
        check("en_clear_status", status_out, 8'h10);
        check("en_clear_int", tx_int, 1'b0);
        check("en_clear_cfg", config_out, 8'h02);
        went_low = 1'b0;
        repeat (20) begin
            if (tx !== 1'b1) went_low = 1'b1;
            @(negedge clk);
        end
        check("held_byte_not_sent", went_low, 1'b0);
        check("held_byte_status", status_out, 8'h10);
        write_cfg(8'h03);
        run_frame(-1, 0, 16'h0, 1'b1, w);
        check("resume_wait", w, 1);
        check("resume_int", tx_int, 1'b1);
        check("resume_status", status_out, 8'h04);

        // asynchronous reset mid-frame
        write_byte(8'h11);
        write_byte(8'h22);
        check("pre_reset_tx_low", tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_status", status_out, 8'h04);
        check("async_rst_int", tx_int, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_div", divisor_out, 16'h000F);
        check("post_rst_cfg", config_out, 8'h00);
        check("post_rst_status", status_out, 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
